// File: rtl/gx4000_io_pkg.sv
// Shared definitions for the GX4000 I/O register bus: register map,
// init-table length, requester identifiers and the init-table contents.
package gx4000_io_pkg;

  localparam logic [7:0] IO_PAGE    = 8'h7F;
  localparam logic [7:0] REG_SWAP   = 8'h70;
  localparam logic [7:0] REG_STATUS = 8'h71;
  localparam logic [7:0] REG_CTRL   = 8'h72;
  localparam logic [7:0] REG_DATA   = 8'h73;
  localparam logic [7:0] REG_DIR    = 8'h74;
  localparam logic [7:0] REG_IRQ    = 8'h75;
  localparam logic [7:0] REG_TIMER  = 8'h76;
  localparam logic [7:0] REG_CLOCK  = 8'h77;

  localparam int INIT_LEN = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {REQ_NONE, REQ_HOST, REQ_INIT} req_e;
  typedef enum logic {ST_INIT, ST_DONE} init_state_e;

  // Register addressed by init step idx (the table walks 0x70..0x77 in order).
  function automatic logic [7:0] init_addr(input int idx);
    return REG_SWAP + 8'(idx);
  endfunction

  // Default value programmed by init step idx; 0x75 gets 00 to clear any pending interrupt.
  function automatic logic [7:0] init_value(input int idx,
                                            input logic [7:0] ctrl,
                                            input logic [7:0] dir,
                                            input logic [7:0] timer);
    logic [7:0] v;
    v = 8'h00;
    case (init_addr(idx))
      REG_CTRL:  v = ctrl;
      REG_DIR:   v = dir;
      REG_TIMER: v = timer;
      default:   v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gx4000_io_init_seq.sv
// Init sequencer: after reset and on every plus_mode rising edge it requests
// the bus until all eight default register writes have been granted.
module gx4000_io_init_seq
  import gx4000_io_pkg::*;
#(
  parameter logic [7:0] INIT_CTRL  = 8'h00,
  parameter logic [7:0] INIT_TIMER = 8'h00,
  parameter logic [7:0] INIT_DIR   = 8'h00
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       plus_mode,
  input  logic       grant,
  output logic       req,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       init_done
);

  logic [7:0]       rom_addr [INIT_LEN];
  logic [7:0]       rom_data [INIT_LEN];
  init_state_e      state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             plus_prev_reg;
  logic             init_done_reg;
  logic             plus_rise;

  // Constant table of (address, value) pairs, one entry per init step.
  generate
    for (genvar gi = 0; gi < INIT_LEN; gi++) begin : g_rom
      assign rom_addr[gi] = init_addr(gi);
      assign rom_data[gi] = init_value(gi, INIT_CTRL, INIT_DIR, INIT_TIMER);
    end
  endgenerate

  assign plus_rise = plus_mode & ~plus_prev_reg;

  // Init FSM: a plus_mode rising edge always restarts, otherwise step on each grant.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      idx_reg       <= '0;
      init_done_reg <= 1'b0;
      // Seed with the live level so a plus_mode already high at reset is not an edge.
      plus_prev_reg <= plus_mode;
    end else begin
      plus_prev_reg <= plus_mode;
      if (plus_rise) begin
        state_reg     <= ST_INIT;
        idx_reg       <= '0;
        init_done_reg <= 1'b0;
      end else if (state_reg == ST_INIT && grant) begin
        if (idx_reg == IDX_W'(INIT_LEN - 1)) begin
          state_reg     <= ST_DONE;
          init_done_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  assign req       = (state_reg == ST_INIT);
  assign addr      = rom_addr[idx_reg];
  assign data      = rom_data[idx_reg];
  assign init_done = init_done_reg;

endmodule

// File: rtl/gx4000_io_bus_arbiter.sv
// GX4000 I/O register bus owner: the CPU passes straight through, and in
// CPU-free cycles one of host or init sequencer is granted round-robin.
module gx4000_io_bus_arbiter
  import gx4000_io_pkg::*;
#(
  parameter logic [7:0] INIT_CTRL  = 8'h00,
  parameter logic [7:0] INIT_TIMER = 8'h00,
  parameter logic [7:0] INIT_DIR   = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_wr,
  output logic        io_rd,
  input  logic [7:0]  io_din,
  output logic        init_done,
  output logic        busy
);

  logic       cpu_active;
  logic       host_ok;
  logic       init_req;
  logic       init_grant;
  logic [7:0] init_addr8;
  logic [7:0] init_data;
  req_e       grant;
  req_e       last_reg;
  logic       host_ack_reg;
  logic [7:0] host_rdata_reg;

  gx4000_io_init_seq #(
    .INIT_CTRL  (INIT_CTRL),
    .INIT_TIMER (INIT_TIMER),
    .INIT_DIR   (INIT_DIR)
  ) u_init_seq (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .plus_mode (plus_mode),
    .grant     (init_grant),
    .req       (init_req),
    .addr      (init_addr8),
    .data      (init_data),
    .init_done (init_done)
  );

  assign cpu_active = cpu_wr | cpu_rd;
  // A request still high in its own ack cycle is the old one; wait a cycle.
  assign host_ok    = host_req & ~host_ack_reg;
  assign init_grant = (grant == REQ_INIT);

  // Round-robin pick between host and init, only in CPU-free cycles outside reset.
  always_comb begin
    grant = REQ_NONE;
    if (!reset && !cpu_active) begin
      if (host_ok && init_req)
        grant = (last_reg == REQ_INIT) ? REQ_HOST : REQ_INIT;
      else if (host_ok)
        grant = REQ_HOST;
      else if (init_req)
        grant = REQ_INIT;
    end
  end

  // Bus mux: CPU (or idle) by default, overridden by the granted internal requester.
  always_comb begin
    io_addr  = cpu_addr;
    io_wdata = cpu_data;
    io_wr    = cpu_wr;
    io_rd    = cpu_rd;
    case (grant)
      REQ_HOST: begin
        io_addr  = {IO_PAGE, host_addr};
        io_wdata = host_wdata;
        io_wr    = host_we;
        io_rd    = ~host_we;
      end
      REQ_INIT: begin
        io_addr  = {IO_PAGE, init_addr8};
        io_wdata = init_data;
        io_wr    = 1'b1;
        io_rd    = 1'b0;
      end
      default: ;
    endcase
  end

  // Host completion, read capture and round-robin history.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      host_ack_reg   <= 1'b0;
      host_rdata_reg <= 8'h00;
      last_reg       <= REQ_HOST;
    end else begin
      host_ack_reg <= (grant == REQ_HOST);
      if (grant == REQ_HOST && !host_we)
        host_rdata_reg <= io_din;
      if (grant != REQ_NONE)
        last_reg <= grant;
    end
  end

  assign host_ack   = host_ack_reg;
  assign host_rdata = host_rdata_reg;
  assign cpu_dout   = io_din;
  assign busy       = init_req | host_req;

endmodule

// File: tb/tb_gx4000_io_bus_arbiter.sv
// Directed bench for gx4000_io_bus_arbiter: init sequence, CPU pass-through,
// host read/write arbitration, plus_mode restart and mid-sequence reset.
module tb_gx4000_io_bus_arbiter;

  logic        clk_sys;
  logic        reset;
  logic        plus_mode;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic        io_wr;
  logic        io_rd;
  logic [7:0]  io_din;
  logic        init_done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Expected init data for INIT_CTRL=C1, INIT_DIR=0F, INIT_TIMER=3E.
  logic [7:0] exp_data [8] = '{8'h00, 8'h00, 8'hC1, 8'h00, 8'h0F, 8'h00, 8'h3E, 8'h00};

  gx4000_io_bus_arbiter #(
    .INIT_CTRL  (8'hC1),
    .INIT_TIMER (8'h3E),
    .INIT_DIR   (8'h0F)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .plus_mode  (plus_mode),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .cpu_dout   (cpu_dout),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_wr      (io_wr),
    .io_rd      (io_rd),
    .io_din     (io_din),
    .init_done  (init_done),
    .busy       (busy)
  );

  // I/O block read model: timer register reads A3, everything else 11.
  assign io_din = (io_addr == 16'h7F76) ? 8'hA3 : 8'h11;

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic chk_init_write(input string tag, input int i);
    check({tag, " io_wr"}, 16'(io_wr), 16'h1);
    check({tag, " io_rd"}, 16'(io_rd), 16'h0);
    check({tag, " io_addr"}, io_addr, 16'h7F70 + 16'(i));
    check({tag, " io_wdata"}, 16'(io_wdata), 16'(exp_data[i]));
    $display("init write %s idx=%0d addr=%h data=%h", tag, i, io_addr, io_wdata);
  endtask

  task automatic chk_bus(input string tag, input logic wr, input logic rd,
                         input logic [15:0] addr, input logic [7:0] data);
    check({tag, " io_wr"}, 16'(io_wr), 16'(wr));
    check({tag, " io_rd"}, 16'(io_rd), 16'(rd));
    check({tag, " io_addr"}, io_addr, addr);
    check({tag, " io_wdata"}, 16'(io_wdata), 16'(data));
    $display("bus %s wr=%b rd=%b addr=%h data=%h", tag, io_wr, io_rd, io_addr, io_wdata);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, " io_wr"}, 16'(io_wr), 16'h0);
    check({tag, " io_rd"}, 16'(io_rd), 16'h0);
  endtask

  initial begin
    reset = 1'b1; plus_mode = 1'b0;
    cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;

    // Reset state
    cyc(); #1;
    check("rst host_ack", 16'(host_ack), 16'h0);
    check("rst host_rdata", 16'(host_rdata), 16'h0);
    check("rst init_done", 16'(init_done), 16'h0);
    check("rst busy", 16'(busy), 16'h1);
    chk_idle("rst");

    // 1: init sequence with idle CPU
    cyc(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      #1;
      chk_init_write("t1", i);
      check("t1 init_done", 16'(init_done), 16'h0);
      check("t1 busy", 16'(busy), 16'h1);
    end
    cyc(); #1;
    check("t1 done", 16'(init_done), 16'h1);
    check("t1 busy end", 16'(busy), 16'h0);
    chk_idle("t1 end");

    // 2: plus_mode restart with CPU writing every other cycle
    cyc(); plus_mode = 1'b1; #1;
    chk_idle("t2 pre");
    for (int k = 0; k < 16; k++) begin
      cyc();
      cpu_wr = (k % 2 == 0); cpu_addr = 16'h7F72; cpu_data = 8'h55;
      #1;
      if (k % 2 == 0) chk_bus("t2 cpu", 1'b1, 1'b0, 16'h7F72, 8'h55);
      else chk_init_write("t2", k / 2);
      check("t2 init_done", 16'(init_done), 16'h0);
    end
    cyc(); cpu_wr = 1'b0; #1;
    check("t2 done", 16'(init_done), 16'h1);
    chk_idle("t2 end");

    // 3: host read of 0x76 while CPU reads for 3 cycles
    for (int k = 0; k < 3; k++) begin
      cyc();
      plus_mode = 1'b0;
      cpu_rd = 1'b1; cpu_addr = 16'h7F72;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h76;
      #1;
      chk_bus("t3 cpu", 1'b0, 1'b1, 16'h7F72, 8'h55);
      check("t3 cpu_dout", 16'(cpu_dout), 16'h11);
      check("t3 ack blocked", 16'(host_ack), 16'h0);
    end
    cyc(); cpu_rd = 1'b0; #1;
    chk_bus("t3 grant", 1'b0, 1'b1, 16'h7F76, 8'h00);
    check("t3 dout grant", 16'(cpu_dout), 16'hA3);
    check("t3 ack grant", 16'(host_ack), 16'h0);
    cyc(); #1;
    check("t3 ack", 16'(host_ack), 16'h1);
    check("t3 rdata", 16'(host_rdata), 16'hA3);
    chk_idle("t3 no regrant");
    cyc(); host_req = 1'b0; #1;
    check("t3 ack drop", 16'(host_ack), 16'h0);
    check("t3 rdata hold", 16'(host_rdata), 16'hA3);
    check("t3 busy", 16'(busy), 16'h0);

    // 4: host write 0x72<-9C concurrent with restarted init
    cyc(); plus_mode = 1'b1; #1;
    chk_idle("t4 pre");
    cyc(); host_req = 1'b1; host_we = 1'b1; host_addr = 8'h72; host_wdata = 8'h9C; #1;
    chk_init_write("t4 first", 0);
    check("t4 ack0", 16'(host_ack), 16'h0);
    cyc(); #1;
    chk_bus("t4 host", 1'b1, 1'b0, 16'h7F72, 8'h9C);
    check("t4 ack1", 16'(host_ack), 16'h0);
    cyc(); #1;
    check("t4 ack", 16'(host_ack), 16'h1);
    chk_init_write("t4 after", 1);
    cyc(); host_req = 1'b0;
    for (int i = 2; i < 8; i++) begin
      if (i > 2) cyc();
      #1;
      chk_init_write("t4", i);
      check("t4 no reack", 16'(host_ack), 16'h0);
    end
    cyc(); #1;
    check("t4 done", 16'(init_done), 16'h1);

    // 5: plus_mode 0->1 while init is at idx 4 (CPU holding the bus)
    cyc(); plus_mode = 1'b0; #1;
    chk_idle("t5 low");
    cyc(); plus_mode = 1'b1; #1;
    chk_idle("t5 rise");
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk_init_write("t5 pre", i);
    end
    cyc(); cpu_wr = 1'b1; cpu_addr = 16'h7F72; cpu_data = 8'h55; plus_mode = 1'b0; #1;
    chk_bus("t5 cpu a", 1'b1, 1'b0, 16'h7F72, 8'h55);
    cyc(); plus_mode = 1'b1; #1;
    chk_bus("t5 cpu b", 1'b1, 1'b0, 16'h7F72, 8'h55);
    cyc(); cpu_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      #1;
      chk_init_write("t5 restart", i);
      check("t5 init_done", 16'(init_done), 16'h0);
    end
    cyc(); #1;
    check("t5 done", 16'(init_done), 16'h1);

    // 6: 1-cycle reset with host_req high and init at idx 5
    cyc(); plus_mode = 1'b0; #1;
    cyc(); plus_mode = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk_init_write("t6 pre", i);
    end
    cyc(); reset = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 8'h74; host_wdata = 8'hEE; #1;
    chk_idle("t6 in reset");
    check("t6 ack rst", 16'(host_ack), 16'h0);
    check("t6 busy rst", 16'(busy), 16'h1);
    cyc(); reset = 1'b0; #1;
    check("t6 ack post", 16'(host_ack), 16'h0);
    check("t6 rdata cleared", 16'(host_rdata), 16'h00);
    check("t6 init_done", 16'(init_done), 16'h0);
    chk_init_write("t6 first", 0);
    cyc(); #1;
    chk_bus("t6 host", 1'b1, 1'b0, 16'h7F74, 8'hEE);
    check("t6 ack1", 16'(host_ack), 16'h0);
    cyc(); #1;
    check("t6 ack", 16'(host_ack), 16'h1);
    chk_init_write("t6 after", 1);
    cyc(); host_req = 1'b0;
    for (int i = 2; i < 8; i++) begin
      if (i > 2) cyc();
      #1;
      chk_init_write("t6", i);
      check("t6 no reack", 16'(host_ack), 16'h0);
    end
    cyc(); #1;
    check("t6 done", 16'(init_done), 16'h1);
    check("t6 busy end", 16'(busy), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
